// File: rtl/jof32_pkg.sv
// rtl/jof32_pkg.sv - shared JOF32 constants, opcodes and fetch FSM encoding
package jof32_pkg;

    localparam int OPC_W  = 5;
    localparam int PC_W   = 10;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [OPC_W-1:0]  HALT_OP   = 5'b11111;

    localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_JMP  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_HALT = HALT_OP;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with load, hold and wrapping increment
module pc_counter #(
    parameter int            W         = 10,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - JOF32 instruction fetch stage with IF/ID pipeline register
module fetch_stage
    import jof32_pkg::*;
#(
    parameter int                   PC_W      = jof32_pkg::PC_W,
    parameter int                   DATA_W    = jof32_pkg::DATA_W,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [DATA_W-1:0]    NOP_INSTR = jof32_pkg::NOP_INSTR,
    parameter logic [OPC_W-1:0]     HALT_OP   = jof32_pkg::HALT_OP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_addr,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic [PC_W-1:0]   pc_id,
    output logic [PC_W-1:0]   pc_plus1_id,
    output logic              valid_id,
    output logic              halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_pend;
    logic            pend_valid;
    logic            running;
    logic            redirect_act;
    logic            advance;
    logic            load_real;

    assign running      = (state_q != ST_HALTED);
    assign redirect_act = running & redirect_en;
    assign advance      = running & ~stall & ~redirect_en;
    // A real IF/ID load happens only when the word returned by memory belongs to a kept fetch
    assign load_real    = advance & pend_valid;

    assign imem_addr = pc_q;
    assign imem_en   = ~stall & running;
    assign halted    = (state_q == ST_HALTED);

    pc_counter #(
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (redirect_act),
        .inc        (advance),
        .load_value (redirect_addr),
        .pc         (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (redirect_act || advance) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_real && (imem_rdata[DATA_W-1 -: OPC_W] == HALT_OP)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_pend     <= '0;
            pend_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            pc_id       <= '0;
            pc_plus1_id <= '0;
            valid_id    <= 1'b0;
        end else if (redirect_act) begin
            pend_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            valid_id    <= 1'b0;
        end else if (advance) begin
            pc_pend    <= pc_q;
            pend_valid <= 1'b1;
            if (pend_valid) begin
                instruction <= imem_rdata;
                pc_id       <= pc_pend;
                pc_plus1_id <= pc_pend + 1'b1;
                valid_id    <= 1'b1;
            end else begin
                instruction <= NOP_INSTR;
                valid_id    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [9:0]  redirect_addr = '0;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [9:0]  pc_id;
    logic [9:0]  pc_plus1_id;
    logic        valid_id;
    logic        halted;

    logic [31:0] mem [1024];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_id         (pc_id),
        .pc_plus1_id   (pc_plus1_id),
        .valid_id      (valid_id),
        .halted        (halted)
    );

    function automatic logic [31:0] word(int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bubble(string name);
        checks++;
        if ({valid_id, instruction} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL %s: valid_id=%0b instruction=%h, required valid_id=0 instruction=00000000",
                     name, valid_id, instruction);
        end
    endtask

    task automatic expect_real(string name, int pc, logic [31:0] instr, int pc1);
        checks++;
        if ({valid_id, pc_id, pc_plus1_id, instruction} !== {1'b1, 10'(pc), 10'(pc1), instr}) begin
            errors++;
            $display("FAIL %s: valid=%0b pc_id=%0d pc_plus1=%0d instr=%h, required valid=1 pc_id=%0d pc_plus1=%0d instr=%h",
                     name, valid_id, pc_id, pc_plus1_id, instruction, pc, pc1, instr);
        end
    endtask

    task automatic do_redirect(int target);
        redirect_en   = 1'b1;
        redirect_addr = 10'(target);
        tick();
        redirect_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({instruction, pc_id, pc_plus1_id, valid_id, halted, imem_addr, imem_en} !==
            {32'h0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: instr=%h pc_id=%0d pc1=%0d valid=%0b halted=%0b addr=%0d en=%0b, required 0/0/0/0/0/0/1",
                     instruction, pc_id, pc_plus1_id, valid_id, halted, imem_addr, imem_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        tick();
        expect_bubble("startup_edge1");
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_real($sformatf("startup_pc%0d", k), k, word(k), k + 1);
        end
    endtask

    task automatic test_redirect();
        do_redirect(200);
        expect_bubble("redirect_bubble1");
        tick();
        expect_bubble("redirect_bubble2");
        tick();
        expect_real("redirect_target", 200, word(200), 201);
        tick();
        expect_real("redirect_next", 201, word(201), 202);
    endtask

    task automatic test_stall();
        do_redirect(6);
        tick();
        tick();
        expect_real("stall_pre6", 6, word(6), 7);
        tick();
        expect_real("stall_pre7", 7, word(7), 8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_real($sformatf("stall_hold%0d", i), 7, word(7), 8);
            checks++;
            if ({imem_addr, imem_en} !== {10'd9, 1'b0}) begin
                errors++;
                $display("FAIL stall_imem%0d: addr=%0d en=%0b, required addr=9 en=0", i, imem_addr, imem_en);
            end
        end
        stall = 1'b0;
        tick();
        expect_real("stall_release8", 8, word(8), 9);
        tick();
        expect_real("stall_release9", 9, word(9), 10);
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        do_redirect(50);
        stall = 1'b0;
        expect_bubble("stallredir_bubble1");
        tick();
        expect_bubble("stallredir_bubble2");
        tick();
        expect_real("stallredir_target", 50, word(50), 51);
    endtask

    task automatic test_wrap();
        do_redirect(1022);
        tick();
        tick();
        expect_real("wrap_1022", 1022, word(1022), 1023);
        tick();
        expect_real("wrap_1023", 1023, word(1023), 0);
        tick();
        expect_real("wrap_0", 0, word(0), 1);
    endtask

    task automatic test_halt();
        mem[5] = {5'b11111, 27'b0};
        do_redirect(3);
        tick();
        tick();
        expect_real("halt_pc3", 3, word(3), 4);
        tick();
        expect_real("halt_pc4", 4, word(4), 5);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_early: halted=%0b, required 0", halted);
        end
        tick();
        expect_real("halt_pc5", 5, 32'hF800_0000, 6);
        checks++;
        if ({halted, imem_en, imem_addr} !== {1'b1, 1'b0, 10'd7}) begin
            errors++;
            $display("FAIL halt_state: halted=%0b en=%0b addr=%0d, required 1/0/7", halted, imem_en, imem_addr);
        end
        tick();
        tick();
        do_redirect(100);
        tick();
        expect_real("halt_frozen", 5, 32'hF800_0000, 6);
        checks++;
        if ({halted, imem_en, imem_addr} !== {1'b1, 1'b0, 10'd7}) begin
            errors++;
            $display("FAIL halt_redirect_ignored: halted=%0b en=%0b addr=%0d, required 1/0/7", halted, imem_en, imem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({halted, valid_id, imem_addr, imem_en} !== {1'b0, 1'b0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL halt_reset: halted=%0b valid=%0b addr=%0d en=%0b, required 0/0/0/1", halted, valid_id, imem_addr, imem_en);
        end
        tick();
        expect_bubble("restart_bubble");
        tick();
        expect_real("restart_pc0", 0, word(0), 1);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = word(k);
        test_reset();
        test_startup();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_wrap();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
